tx_preamble_inserter: RTL and testbench
=======================================

# tx_preamble_inserter

Sits between the QPSK mapper and the pulse shaper in the TX chain. On each new frame it emits a fixed PN7-derived QPSK preamble, then forwards the frame's payload symbols unchanged. It optionally appends a zero-valued guard interval after the frame. Output is a registered valid/ready stream of Q1.15 I/Q symbols running at one symbol per cycle.

## Interface
- PREAMBLE_LEN, 32: preamble length in symbols; legal range 1..256.
- GUARD_LEN, 8: guard length in zero symbols; legal range 1..256; used only with TX_GUARD_EN.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- s_axis_valid  in  1  input symbol valid.
- s_axis_ready  out  1  input accepted when valid && ready.
- s_axis_i, s_axis_q  in  16  signed Q1.15 symbol components.
- s_axis_sop  in  1  first symbol of a frame.
- s_axis_last  in  1  last symbol of a frame.
- s_axis_is_parity  in  1  symbol carries parity bits.
- m_axis_valid  out  1  output symbol valid.
- m_axis_ready  in  1  downstream ready.
- m_axis_i, m_axis_q  out  16  signed Q1.15 output symbol.
- m_axis_sop  out  1  first preamble symbol of a frame.
- m_axis_last  out  1  final symbol of a frame, including guard.
- m_axis_is_parity  out  1  forwarded parity flag; 0 for preamble and guard symbols.
- m_axis_is_preamble  out  1  symbol belongs to the preamble.
- drop_cnt  out  16  saturating count of discarded out-of-frame input symbols.

## Operation
- States:
  - IDLE: s_axis_ready = 1.
    - Accepted beat without sop: discard it and increment drop_cnt, saturating at 0xFFFF.
    - Input with sop valid: do not accept it; reseed the LFSR; go to PREAMBLE.
  - PREAMBLE: s_axis_ready = 0.
    - Emit PREAMBLE_LEN symbols, then go to PAYLOAD.
  - PAYLOAD: forward input symbols to the output register; input sop is masked to 0.
    - After the beat with s_axis_last is accepted: go to GUARD (TX_GUARD_EN) or IDLE.
  - GUARD: s_axis_ready = 0.
    - Emit GUARD_LEN symbols with i = q = 0, then go to IDLE.
- Preamble generator:
  - Fibonacci LFSR, x^7+x^6+1, seed 7'h7F.
  - Output bit is state[6]; next state is {state[5:0], state[6]^state[5]}.
  - Two bits per symbol, first bit to I, second to Q.
  - Bit 1 maps to +23170 (0x5A82); bit 0 maps to -23170 (0xA57E).
  - LFSR advances only when a preamble symbol is loaded into the output register.
- A sop arriving mid-PAYLOAD is forwarded as a normal symbol with sop cleared. It does not restart the preamble.
- A frame whose single symbol carries both sop and last is legal: preamble, then that symbol, then guard if enabled.
- Symbol counter is 8 bits and counts 0..LEN-1; the state transition occurs on the load of symbol LEN-1.

## Timing
- Output register loads when (!m_axis_valid || m_axis_ready); this is the only advance condition for all states.
- In PAYLOAD, s_axis_ready = !m_axis_valid || m_axis_ready.
- Latency:
  - Input-to-output is 1 cycle.
  - First preamble symbol is valid 1 cycle after the IDLE cycle in which the sop beat is presented.
- No bubbles at PREAMBLE→PAYLOAD, PAYLOAD→GUARD or GUARD→IDLE→PREAMBLE boundaries when input is available and downstream is ready. Sustained throughput is 1 symbol/cycle.
- Output fields hold stable while m_axis_valid && !m_axis_ready.
- Reset:
  - All outputs return to 0, the state returns to IDLE, and the LFSR is reseeded to 7'h7F. drop_cnt also returns to 0.
  - Reset mid-frame discards the symbol in flight and the remainder of the frame. The first post-reset sop starts a clean preamble.

## Configuration
- TX_GUARD_EN defined:
  - GUARD state is compiled in.
  - m_axis_last is asserted only on the final guard symbol; the payload last is forwarded as 0.
- TX_GUARD_EN undefined:
  - GUARD state and GUARD_LEN logic are absent.
  - m_axis_last is forwarded from the payload last beat; the FSM goes directly from PAYLOAD to IDLE.

## Test plan
- PREAMBLE_LEN=4, ready tied high, 3-symbol frame. Required response:
  - Outputs (+,+),(+,+),(+,+),(+,-) with sop on the first and is_preamble=1 on all four.
  - Then the 3 payload symbols, unchanged, with is_preamble=0.
- TX_GUARD_EN, GUARD_LEN=2: the frame is followed by two (0,0) symbols; m_axis_last is on the second guard symbol only.
- 5 symbols without sop while IDLE: all are accepted and drop_cnt=5; no m_axis_valid.
- Random m_axis_ready backpressure of 50% over 100 frames: output data is stable while stalled; no loss or duplication; the preamble restarts at (+,+) for every frame.
- Reset asserted mid-payload: next cycle m_axis_valid=0 and drop_cnt=0; next sop produces a full preamble starting at (+,+).
- Single-symbol frame with sop=last=1 and is_parity=1: PREAMBLE_LEN preamble symbols with is_parity=0, then the symbol with is_parity=1. last is set on that symbol (no guard) or on the final guard symbol (guard).

Source files
------------

// File: rtl/tx_preamble_inserter.sv
// tx_preamble_inserter: puts a PN7-derived QPSK preamble in front of each
// frame, forwards the payload symbols unchanged, and optionally appends a
// zero-valued guard interval.
// Optional feature macro: TX_GUARD_EN (guard interval after each frame).
// The output is a single registered valid/ready stage at 1 symbol/cycle.
module tx_preamble_inserter #(
   parameter int PREAMBLE_LEN = 32,
   parameter int GUARD_LEN    = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               s_axis_valid,
   output logic               s_axis_ready,
   input  logic signed [15:0] s_axis_i,
   input  logic signed [15:0] s_axis_q,
   input  logic               s_axis_sop,
   input  logic               s_axis_last,
   input  logic               s_axis_is_parity,
   output logic               m_axis_valid,
   input  logic               m_axis_ready,
   output logic signed [15:0] m_axis_i,
   output logic signed [15:0] m_axis_q,
   output logic               m_axis_sop,
   output logic               m_axis_last,
   output logic               m_axis_is_parity,
   output logic               m_axis_is_preamble,
   output logic [15:0]        drop_cnt
);

   localparam logic [6:0]         LFSR_SEED = 7'h7F;
   localparam logic signed [15:0] SYM_P     = 16'sh5A82;
   localparam logic signed [15:0] SYM_N     = 16'shA57E;
   localparam logic [7:0]         PRE_LAST  = 8'(PREAMBLE_LEN - 1);
`ifdef TX_GUARD_EN
   localparam logic [7:0]         GRD_LAST  = 8'(GUARD_LEN - 1);
`endif

   // Elaboration-time range checks on the length parameters.
   if (PREAMBLE_LEN < 1 || PREAMBLE_LEN > 256) begin : g_bad_pre_len
      $error("PREAMBLE_LEN must be in 1..256");
   end
   if (GUARD_LEN < 1 || GUARD_LEN > 256) begin : g_bad_grd_len
      $error("GUARD_LEN must be in 1..256");
   end

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
`ifdef TX_GUARD_EN
      ST_PAYLOAD  = 2'd2,
      ST_GUARD    = 2'd3
`else
      ST_PAYLOAD  = 2'd2
`endif
   } state_t;

   state_t             state, state_nxt;
   logic [7:0]         cnt, cnt_nxt;
   logic [6:0]         lfsr, lfsr_src, lfsr_step;
   logic               out_ld;
   logic               lfsr_adv, drop_inc;
   logic               sym_vld, sym_sop, sym_last, sym_par, sym_pre;
   logic signed [15:0] sym_i, sym_q, pre_i, pre_q;

   // The output register is the single point of advance for every state.
   assign out_ld = !m_axis_valid || m_axis_ready;

   // In IDLE the generator always starts from the seed, so the first
   // preamble symbol can be loaded in the same cycle the sop is seen.
   // Each symbol consumes two LFSR bits: I = bit n, Q = bit n+1.
   assign lfsr_src  = (state == ST_IDLE) ? LFSR_SEED : lfsr;
   assign lfsr_step = {lfsr_src[4:0], lfsr_src[6] ^ lfsr_src[5], lfsr_src[5] ^ lfsr_src[4]};
   assign pre_i     = lfsr_src[6] ? SYM_P : SYM_N;
   assign pre_q     = lfsr_src[5] ? SYM_P : SYM_N;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next state, input ready and the symbol to load into the output register.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      s_axis_ready = 1'b0;
      sym_vld      = 1'b0;
      sym_i        = '0;
      sym_q        = '0;
      sym_sop      = 1'b0;
      sym_last     = 1'b0;
      sym_par      = 1'b0;
      sym_pre      = 1'b0;
      lfsr_adv     = 1'b0;
      drop_inc     = 1'b0;
      case (state)
         ST_IDLE: begin
            // The sop beat is held back (not handshaked) so it becomes the
            // first payload symbol once the preamble is out.
            s_axis_ready = !(s_axis_valid && s_axis_sop);
            if (s_axis_valid && !s_axis_sop) begin
               drop_inc = 1'b1;
            end else if (s_axis_valid && s_axis_sop && out_ld) begin
               sym_vld  = 1'b1;
               sym_i    = pre_i;
               sym_q    = pre_q;
               sym_sop  = 1'b1;
               sym_pre  = 1'b1;
               lfsr_adv = 1'b1;
               cnt_nxt  = (PRE_LAST == 8'd0) ? 8'd0 : 8'd1;
               state_nxt = (PRE_LAST == 8'd0) ? ST_PAYLOAD : ST_PREAMBLE;
            end
         end
         ST_PREAMBLE: begin
            if (out_ld) begin
               sym_vld  = 1'b1;
               sym_i    = pre_i;
               sym_q    = pre_q;
               sym_pre  = 1'b1;
               lfsr_adv = 1'b1;
               if (cnt == PRE_LAST) begin
                  cnt_nxt   = 8'd0;
                  state_nxt = ST_PAYLOAD;
               end else begin
                  cnt_nxt = cnt + 8'd1;
               end
            end
         end
         ST_PAYLOAD: begin
            s_axis_ready = out_ld;
            if (out_ld && s_axis_valid) begin
               sym_vld = 1'b1;
               sym_i   = s_axis_i;
               sym_q   = s_axis_q;
               sym_par = s_axis_is_parity;
`ifdef TX_GUARD_EN
               sym_last = 1'b0;
               if (s_axis_last) begin
                  cnt_nxt   = 8'd0;
                  state_nxt = ST_GUARD;
               end
`else
               sym_last = s_axis_last;
               if (s_axis_last) begin
                  cnt_nxt   = 8'd0;
                  state_nxt = ST_IDLE;
               end
`endif
            end
         end
`ifdef TX_GUARD_EN
         ST_GUARD: begin
            if (out_ld) begin
               sym_vld = 1'b1;
               if (cnt == GRD_LAST) begin
                  sym_last  = 1'b1;
                  cnt_nxt   = 8'd0;
                  state_nxt = ST_IDLE;
               end else begin
                  cnt_nxt = cnt + 8'd1;
               end
            end
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output register, symbol counter, LFSR and drop counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_axis_valid       <= 1'b0;
         m_axis_i           <= '0;
         m_axis_q           <= '0;
         m_axis_sop         <= 1'b0;
         m_axis_last        <= 1'b0;
         m_axis_is_parity   <= 1'b0;
         m_axis_is_preamble <= 1'b0;
         cnt                <= 8'd0;
         lfsr               <= LFSR_SEED;
         drop_cnt           <= 16'd0;
      end else begin
         cnt <= cnt_nxt;
         if (lfsr_adv) lfsr <= lfsr_step;
         if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         if (out_ld) begin
            m_axis_valid <= sym_vld;
            if (sym_vld) begin
               m_axis_i           <= sym_i;
               m_axis_q           <= sym_q;
               m_axis_sop         <= sym_sop;
               m_axis_last        <= sym_last;
               m_axis_is_parity   <= sym_par;
               m_axis_is_preamble <= sym_pre;
            end
         end
      end
   end

endmodule

// File: tb/tb_tx_preamble_inserter.sv
// Directed bench for tx_preamble_inserter with PREAMBLE_LEN=4, GUARD_LEN=2.
// Expected symbols come from a hand-written preamble table and the frame
// contents the bench itself drives; a monitor pops them in order.
module tb_tx_preamble_inserter;

   localparam int PRE_LEN = 4;
   localparam int GRD_LEN = 2;
`ifdef TX_GUARD_EN
   localparam bit GUARD_ON = 1'b1;
`else
   localparam bit GUARD_ON = 1'b0;
`endif
   localparam logic [15:0] P = 16'h5A82;
   localparam logic [15:0] N = 16'hA57E;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid, s_ready, s_sop, s_last, s_par;
   logic [15:0] s_i, s_q;
   logic        m_valid, m_ready, m_sop, m_last, m_par, m_pre;
   logic [15:0] m_i, m_q;
   logic [15:0] drop_cnt;

   tx_preamble_inserter #(.PREAMBLE_LEN(PRE_LEN), .GUARD_LEN(GRD_LEN)) dut (
      .clk(clk), .rst(rst),
      .s_axis_valid(s_valid), .s_axis_ready(s_ready),
      .s_axis_i(s_i), .s_axis_q(s_q),
      .s_axis_sop(s_sop), .s_axis_last(s_last), .s_axis_is_parity(s_par),
      .m_axis_valid(m_valid), .m_axis_ready(m_ready),
      .m_axis_i(m_i), .m_axis_q(m_q),
      .m_axis_sop(m_sop), .m_axis_last(m_last),
      .m_axis_is_parity(m_par), .m_axis_is_preamble(m_pre),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [35:0] pk(input logic [15:0] i, input logic [15:0] q,
                                      input logic sop, input logic last,
                                      input logic par, input logic pre);
      return {i, q, sop, last, par, pre};
   endfunction

   // Preamble for seed 7'h7F, worked out by hand: (+,+),(+,+),(+,+),(+,-).
   logic [15:0] pre_i_tab [PRE_LEN] = '{P, P, P, P};
   logic [15:0] pre_q_tab [PRE_LEN] = '{P, P, P, N};

   int cyc = 0;
   always @(posedge clk) cyc++;

   bit rdy_rand = 1'b0;
   always @(posedge clk) begin
      #1;
      m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   logic [35:0] exp_q[$];
   bit          mon_en = 1'b0;
   bit          stalled = 1'b0;
   logic [35:0] held;
   int          first_cyc = -1;
   int          last_cyc = 0;
   int          n_out = 0;
   int          last_pres = 0;

   wire [35:0] cur = {m_i, m_q, m_sop, m_last, m_par, m_pre};

   // Output monitor: in-order compare, plus hold check while stalled.
   always @(negedge clk) begin
      if (rst || !mon_en) begin
         stalled = 1'b0;
      end else begin
         if (stalled) chk("stall_hold", {m_valid, cur}, {1'b1, held});
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("unexpected_out_qsize", exp_q.size(), 1);
            else chk("out_sym", cur, exp_q.pop_front());
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            n_out++;
         end
         stalled = m_valid && !m_ready;
         held    = cur;
      end
   end

   // Present one beat (caller is just past a rising edge) and wait for it.
   task automatic drive_beat(input logic [15:0] i, input logic [15:0] q,
                             input logic sop, input logic last, input logic par);
      bit hs = 1'b0;
      s_valid = 1'b1; s_i = i; s_q = q; s_sop = sop; s_last = last; s_par = par;
      for (int k = 0; k < 300 && !hs; k++) begin
         @(negedge clk);
         hs = s_ready;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0; s_sop = 1'b0; s_last = 1'b0;
      if (!hs) chk("hs_timeout", hs, 1);
   endtask

   task automatic send_frame(input int n, input logic [15:0] seed,
                             input bit mid_sop, input logic [3:0] par_bits);
      logic [15:0] di, dq;
      for (int p = 0; p < PRE_LEN; p++)
         exp_q.push_back(pk(pre_i_tab[p], pre_q_tab[p], p == 0, 1'b0, 1'b0, 1'b1));
      for (int k = 0; k < n; k++) begin
         di = seed + 16'(k * 16'h0111);
         dq = ~di ^ 16'(k);
         exp_q.push_back(pk(di, dq, 1'b0, !GUARD_ON && (k == n - 1), par_bits[k], 1'b0));
      end
      if (GUARD_ON)
         for (int g = 0; g < GRD_LEN; g++)
            exp_q.push_back(pk(16'h0, 16'h0, 1'b0, g == GRD_LEN - 1, 1'b0, 1'b0));
      last_pres = cyc;
      for (int k = 0; k < n; k++) begin
         di = seed + 16'(k * 16'h0111);
         dq = ~di ^ 16'(k);
         drive_beat(di, dq, (k == 0) || (mid_sop && k == 1), k == n - 1, par_bits[k]);
      end
   endtask

   task automatic wait_drain(input string tag);
      for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(posedge clk);
      @(negedge clk);
      chk(tag, exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int pres_a;
      rst = 1'b1; s_valid = 1'b0; s_i = '0; s_q = '0;
      s_sop = 1'b0; s_last = 1'b0; s_par = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", m_valid, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_fields", cur, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      chk("idle_ready", s_ready, 1);
      @(posedge clk); #1;

      // Out-of-frame beats are swallowed and counted.
      for (int k = 0; k < 5; k++) drive_beat(16'(k), 16'(k + 7), 1'b0, 1'(k == 4), 1'b0);
      @(negedge clk);
      chk("drop_cnt5", drop_cnt, 5);
      chk("drop_no_valid", m_valid, 0);
      @(posedge clk); #1;

      // Back-to-back directed frames at full rate: plain 3-symbol frame,
      // frame with a stray mid-payload sop, single sop+last parity symbol.
      first_cyc = -1; n_out = 0;
      send_frame(3, 16'h1000, 1'b0, 4'b0010);
      pres_a = last_pres;
      send_frame(3, 16'h2000, 1'b1, 4'b0101);
      send_frame(1, 16'h7FFF, 1'b0, 4'b0001);
      wait_drain("drain_directed");
      chk("sop_latency", first_cyc, pres_a + 1);
      chk("out_count", n_out, 3 * PRE_LEN + 7 + (GUARD_ON ? 3 * GRD_LEN : 0));
      chk("no_bubble", last_cyc - first_cyc + 1, n_out);
      chk("drop_hold", drop_cnt, 5);

      // 100 random frames under 50% downstream backpressure.
      @(posedge clk); #1;
      rdy_rand = 1'b1;
      for (int f = 0; f < 100; f++)
         send_frame($urandom_range(1, 4), 16'($urandom), 1'($urandom_range(0, 1)),
                    4'($urandom));
      wait_drain("drain_random");
      rdy_rand = 1'b0;

      // Reset in the middle of a payload.
      @(posedge clk); #1;
      mon_en = 1'b0;
      drive_beat(16'h3333, 16'h4444, 1'b1, 1'b0, 1'b0);
      drive_beat(16'h3334, 16'h4445, 1'b0, 1'b0, 1'b0);
      drive_beat(16'h3335, 16'h4446, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_valid", m_valid, 0);
      chk("midrst_drop", drop_cnt, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      mon_en = 1'b1;
      @(negedge clk);
      chk("midrst_idle_ready", s_ready, 1);
      @(posedge clk); #1;
      send_frame(2, 16'h5000, 1'b0, 4'b0011);
      wait_drain("drain_post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
